ex_muldiv_unit: RTL

- Iterative RV32M multiply/divide unit in the EX stage. It is the consumer of the ID/EX pipeline register outputs (ALU_OP, READ_DATA1/2, DEST_REG) whenever ALU_OP selects an M-extension operation.
- It runs a shift-add multiply or a restoring divide over XLEN cycles.
- While working it raises STALL to freeze IF/ID/ID_EX. On completion it returns the result with the destination register and a one-cycle DONE/write-enable.

---
 rtl/ex_muldiv_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and
// restoring divide over XLEN cycles, stalling the front end until the result is ready.
module ex_muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            START,
  input  logic [4:0]      ALU_OP,
  input  logic [XLEN-1:0] OP_A,
  input  logic [XLEN-1:0] OP_B,
  input  logic [4:0]      DEST_REG,
  input  logic            FLUSH,
  output logic            STALL,
  output logic            DONE,
  output logic [XLEN-1:0] RESULT,
  output logic [4:0]      OUT_DEST_REG,
  output logic            OUT_REG_WRITE_ENABLE
);

  localparam int CNT_W = $clog2(XLEN);

  localparam logic [1:0] SEL_LO  = 2'd0;
  localparam logic [1:0] SEL_HI  = 2'd1;
  localparam logic [1:0] SEL_QUO = 2'd2;
  localparam logic [1:0] SEL_REM = 2'd3;

  typedef enum logic [1:0] {IDLE, CALC, FINAL, DONE_S} state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    counter_reg;
  logic [1:0]          sel_reg;
  logic                sign_a_reg;
  logic                sign_b_reg;
  logic [4:0]          dest_reg;
  logic [2*XLEN-1:0]   work_reg;
  logic [XLEN-1:0]     opnd_reg;

  logic [1:0]          dec_sel;
  logic                dec_a_signed;
  logic                dec_b_signed;
  logic                dec_is_div;
  logic                neg_a;
  logic                neg_b;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                div_zero;
  logic                div_ovf;
  logic [XLEN-1:0]     fast_result;
  logic                accept;

  always_comb begin
    dec_sel      = SEL_LO;
    dec_a_signed = 1'b0;
    dec_b_signed = 1'b0;
    case (ALU_OP)
      5'b01001: begin dec_sel = SEL_HI;  dec_a_signed = 1'b1; dec_b_signed = 1'b1; end
      5'b01010: begin dec_sel = SEL_HI;  dec_a_signed = 1'b1; end
      5'b01011: begin dec_sel = SEL_HI;  end
      5'b01100: begin dec_sel = SEL_QUO; dec_a_signed = 1'b1; dec_b_signed = 1'b1; end
      5'b01101: begin dec_sel = SEL_QUO; end
      5'b01110: begin dec_sel = SEL_REM; dec_a_signed = 1'b1; dec_b_signed = 1'b1; end
      5'b01111: begin dec_sel = SEL_REM; end
      default:  begin dec_sel = SEL_LO;  end
    endcase
  end

  assign dec_is_div = dec_sel[1];
  assign neg_a      = dec_a_signed & OP_A[XLEN-1];
  assign neg_b      = dec_b_signed & OP_B[XLEN-1];
  assign mag_a      = neg_a ? -OP_A : OP_A;
  assign mag_b      = neg_b ? -OP_B : OP_B;

  // Divide-by-zero and signed overflow finish at accept without iterating.
  assign div_zero = dec_is_div & (OP_B == '0);
  assign div_ovf  = dec_is_div & dec_a_signed & (OP_A == {1'b1, {(XLEN-1){1'b0}}}) & (OP_B == '1);
  assign fast_result = div_zero ? ((dec_sel == SEL_REM) ? OP_A : '1)
                                : ((dec_sel == SEL_REM) ? '0 : OP_A);

  assign accept = START & ~FLUSH & ((state_reg == IDLE) | (state_reg == DONE_S));

  assign STALL = (START & (state_reg == IDLE) & ~FLUSH) | (state_reg == CALC) | (state_reg == FINAL);
  assign DONE                 = (state_reg == DONE_S);
  assign OUT_REG_WRITE_ENABLE = DONE;

  // work_reg is {partial product hi, multiplier} for multiply and {remainder, dividend/quotient} for divide.
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic                div_ge;
  logic [XLEN-1:0]     div_diff;
  logic [2*XLEN-1:0]   work_step;
  logic                is_div_reg;

  assign is_div_reg = sel_reg[1];
  assign mul_sum    = {1'b0, work_reg[2*XLEN-1:XLEN]} + (work_reg[0] ? {1'b0, opnd_reg} : '0);
  assign div_shift  = {work_reg[2*XLEN-1:XLEN], work_reg[XLEN-1]};
  assign div_ge     = (div_shift >= {1'b0, opnd_reg});
  assign div_diff   = div_shift[XLEN-1:0] - opnd_reg;
  assign work_step  = is_div_reg
                      ? {(div_ge ? div_diff : div_shift[XLEN-1:0]), work_reg[XLEN-2:0], div_ge}
                      : {mul_sum, work_reg[XLEN-1:1]};

  logic                neg_res;
  logic [2*XLEN-1:0]   prod_final;
  logic [XLEN-1:0]     quo_final;
  logic [XLEN-1:0]     rem_final;
  logic [XLEN-1:0]     final_result;

  assign neg_res    = sign_a_reg ^ sign_b_reg;
  assign prod_final = neg_res ? -work_reg : work_reg;
  assign quo_final  = neg_res ? -work_reg[XLEN-1:0] : work_reg[XLEN-1:0];
  assign rem_final  = sign_a_reg ? -work_reg[2*XLEN-1:XLEN] : work_reg[2*XLEN-1:XLEN];

  always_comb begin
    final_result = prod_final[XLEN-1:0];
    case (sel_reg)
      SEL_HI:  final_result = prod_final[2*XLEN-1:XLEN];
      SEL_QUO: final_result = quo_final;
      SEL_REM: final_result = rem_final;
      default: final_result = prod_final[XLEN-1:0];
    endcase
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state_reg    <= IDLE;
      counter_reg  <= '0;
      sel_reg      <= SEL_LO;
      sign_a_reg   <= 1'b0;
      sign_b_reg   <= 1'b0;
      dest_reg     <= '0;
      work_reg     <= '0;
      opnd_reg     <= '0;
      RESULT       <= '0;
      OUT_DEST_REG <= '0;
    end else begin
      case (state_reg)
        IDLE, DONE_S: begin
          if (accept) begin
            sel_reg     <= dec_sel;
            dest_reg    <= DEST_REG;
            sign_a_reg  <= neg_a;
            sign_b_reg  <= neg_b;
            counter_reg <= '0;
            if (div_zero | div_ovf) begin
              RESULT       <= fast_result;
              OUT_DEST_REG <= DEST_REG;
              state_reg    <= DONE_S;
            end else begin
              work_reg  <= dec_is_div ? {{XLEN{1'b0}}, mag_a} : {{XLEN{1'b0}}, mag_b};
              opnd_reg  <= dec_is_div ? mag_b : mag_a;
              state_reg <= CALC;
            end
          end else begin
            state_reg <= IDLE;
          end
        end
        CALC: begin
          if (FLUSH) begin
            state_reg <= IDLE;
          end else begin
            work_reg    <= work_step;
            counter_reg <= counter_reg + 1'b1;
            if (counter_reg == CNT_W'(XLEN-1)) state_reg <= FINAL;
          end
        end
        FINAL: begin
          if (FLUSH) begin
            state_reg <= IDLE;
          end else begin
            RESULT       <= final_result;
            OUT_DEST_REG <= dest_reg;
            state_reg    <= DONE_S;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
